// File: rtl/rv32i_pkg.sv
// Shared constants for the RV32I field encoder.
// Format codes, base opcodes, the NOP word and an immediate-fit helper.
package rv32i_pkg;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    // True when v[31:msb] are all copies of the same bit.
    function automatic logic imm_fits(input logic [31:0] v, input int unsigned msb);
        logic [31:0] s;
        s = 32'($signed(v) >>> msb);
        return (s == '0) || (s == '1);
    endfunction

endpackage

// File: rtl/rv32i_imm_pack.sv
// Combinational packer: instruction fields plus immediate to a 32-bit word.
// Out-of-range immediates and unknown formats yield the NOP word.
module rv32i_imm_pack
    import rv32i_pkg::*;
(
    input  logic [2:0]  fmt_i,
    input  logic [6:0]  opcode_i,
    input  logic [4:0]  rd_i,
    input  logic [2:0]  funct3_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [6:0]  funct7_i,
    input  logic [31:0] imm_i,
    output logic [31:0] word_o,
    output logic [1:0]  err_o
);

    logic [31:0] raw;

    always_comb begin
        raw   = '0;
        err_o = '0;
        unique case (1'b1)
            (fmt_i == FMT_R): begin
                raw = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            end
            (fmt_i == FMT_I): begin
                raw      = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
                err_o[0] = !imm_fits(imm_i, 11);
            end
            (fmt_i == FMT_S): begin
                raw      = {imm_i[11:5], rs2_i, rs1_i, funct3_i,
                            imm_i[4:0], opcode_i};
                err_o[0] = !imm_fits(imm_i, 11);
            end
            (fmt_i == FMT_B): begin
                raw      = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                            imm_i[4:1], imm_i[11], opcode_i};
                err_o[0] = !imm_fits(imm_i, 12) || imm_i[0];
            end
            (fmt_i == FMT_U): begin
                raw      = {imm_i[31:12], rd_i, opcode_i};
                err_o[0] = |imm_i[11:0];
            end
            (fmt_i == FMT_J): begin
                raw      = {imm_i[20], imm_i[10:1], imm_i[11],
                            imm_i[19:12], rd_i, opcode_i};
                err_o[0] = !imm_fits(imm_i, 20) || imm_i[0];
            end
            default: err_o[1] = 1'b1;
        endcase
        word_o = (|err_o) ? NOP_WORD : raw;
    end

endmodule

// File: rtl/rv32i_encoder.sv
// Two-stage valid/ready RV32I encoder with auto-incrementing byte address
// and a sticky error flag, feeding a program loader or instruction ROM.
module rv32i_encoder
    import rv32i_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [2:0]        funct3,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    input  logic              addr_clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] addr,
    output logic [1:0]        out_err,
    output logic              err_sticky
);

    logic [31:0]       pk_word;
    logic [1:0]        pk_err;
    logic              s1_full_q, s1_full_d;
    logic [31:0]       s1_word_q;
    logic [1:0]        s1_err_q;
    logic              s2_full_q, s2_full_d;
    logic [31:0]       instr_q;
    logic [1:0]        err_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              sticky_q, sticky_d;
    logic              out_hs, s1_adv, s1_load, s2_load;

    rv32i_imm_pack u_pack (
        .fmt_i    (fmt),
        .opcode_i (opcode),
        .rd_i     (rd),
        .funct3_i (funct3),
        .rs1_i    (rs1),
        .rs2_i    (rs2),
        .funct7_i (funct7),
        .imm_i    (imm),
        .word_o   (pk_word),
        .err_o    (pk_err)
    );

    assign out_hs   = s2_full_q && out_ready;
    assign s1_adv   = !s2_full_q || out_hs;
    assign in_ready = !s1_full_q || s1_adv;
    assign s1_load  = in_valid && in_ready;
    assign s2_load  = s1_full_q && s1_adv;

    always_comb begin
        s1_full_d = s1_full_q;
        s2_full_d = s2_full_q;
        addr_d    = addr_q;
        sticky_d  = sticky_q;
        if (s1_load)     s1_full_d = 1'b1;
        else if (s1_adv) s1_full_d = 1'b0;
        if (s2_load)     s2_full_d = 1'b1;
        else if (out_hs) s2_full_d = 1'b0;
        // A coincident clear beats the handshake's increment and sticky update.
        if (addr_clr) begin
            addr_d   = BASE_ADDR;
            sticky_d = 1'b0;
        end else if (out_hs) begin
            addr_d   = addr_q + ADDR_W'(4);
            sticky_d = sticky_q || (|err_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_full_q <= 1'b0;
            s2_full_q <= 1'b0;
            addr_q    <= BASE_ADDR;
            sticky_q  <= 1'b0;
        end else begin
            s1_full_q <= s1_full_d;
            s2_full_q <= s2_full_d;
            addr_q    <= addr_d;
            sticky_q  <= sticky_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_word_q <= '0;
            s1_err_q  <= '0;
            instr_q   <= '0;
            err_q     <= '0;
        end else begin
            if (s1_load) begin
                s1_word_q <= pk_word;
                s1_err_q  <= pk_err;
            end
            if (s2_load) begin
                instr_q <= s1_word_q;
                err_q   <= s1_err_q;
            end
        end
    end

    assign out_valid  = s2_full_q;
    assign instr      = instr_q;
    assign out_err    = err_q;
    assign addr       = addr_q;
    assign err_sticky = sticky_q;

endmodule

// File: tb/tb_rv32i_encoder.sv
// Randomized bench for rv32i_encoder: a scoreboard decodes every emitted word
// back to fields and checks it against arithmetic range rules.
module tb_rv32i_encoder;
    import rv32i_pkg::*;

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        has;
        logic [31:0] word;
    } item_t;

    logic        clk, rst_n, in_valid, addr_clr, out_ready;
    logic        in_ready, out_valid, err_sticky;
    logic [31:0] instr, addr;
    logic [1:0]  out_err;
    logic        in_ready4, out_valid4, sticky4;
    logic [31:0] instr4;
    logic [3:0]  addr4;
    logic [1:0]  err4;

    item_t       cur;
    item_t       sb[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] m_addr;
    logic        m_sticky;
    bit          stalled, accepted;
    logic [31:0] p_instr, p_addr;

    rv32i_encoder u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(cur.fmt), .opcode(cur.op), .rd(cur.rd), .funct3(cur.f3),
        .rs1(cur.rs1), .rs2(cur.rs2), .funct7(cur.f7), .imm(cur.imm),
        .addr_clr(addr_clr), .out_valid(out_valid), .out_ready(out_ready),
        .instr(instr), .addr(addr), .out_err(out_err), .err_sticky(err_sticky)
    );

    rv32i_encoder #(.ADDR_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .fmt(cur.fmt), .opcode(cur.op), .rd(cur.rd), .funct3(cur.f3),
        .rs1(cur.rs1), .rs2(cur.rs2), .funct7(cur.f7), .imm(cur.imm),
        .addr_clr(addr_clr), .out_valid(out_valid4), .out_ready(out_ready),
        .instr(instr4), .addr(addr4), .out_err(err4), .err_sticky(sticky4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic item_t mk(input int f, input int op, input int rd_v,
                                 input int f3, input int r1, input int r2,
                                 input int f7, input logic [31:0] im,
                                 input logic [31:0] w);
        item_t it;
        it.fmt = 3'(f); it.op = 7'(op); it.rd = 5'(rd_v); it.f3 = 3'(f3);
        it.rs1 = 5'(r1); it.rs2 = 5'(r2); it.f7 = 7'(f7); it.imm = im;
        it.has = 1'b1; it.word = w;
        return it;
    endfunction

    function automatic item_t rnd_item();
        item_t it;
        int    mode;
        it.fmt = 3'($urandom_range(0, 7));
        it.op  = 7'($urandom); it.rd  = 5'($urandom); it.f3 = 3'($urandom);
        it.rs1 = 5'($urandom); it.rs2 = 5'($urandom); it.f7 = 7'($urandom);
        it.has = 1'b0; it.word = '0;
        mode = int'($urandom_range(0, 3));
        it.imm = $urandom;
        if (mode != 0) begin
            case (it.fmt)
                3'd1, 3'd2: it.imm = $urandom_range(0, 4095) - 2048;
                3'd3: it.imm = ($urandom_range(0, 8191) - 4096) & ~32'd1;
                3'd4: it.imm = $urandom & 32'hFFFF_F000;
                3'd5: it.imm = ($urandom_range(0, 2097151) - 1048576) & ~32'd1;
                default: it.imm = $urandom;
            endcase
        end
        return it;
    endfunction

    // Expected error bits from the legal numeric range of each format.
    function automatic logic [1:0] exp_err(input logic [2:0] f,
                                           input logic [31:0] im);
        int s;
        s = int'(im);
        case (f)
            3'd0: return 2'b00;
            3'd1, 3'd2: return {1'b0, (s < -2048) || (s > 2047)};
            3'd3: return {1'b0, (s < -4096) || (s > 4095) || (s % 2 != 0)};
            3'd4: return {1'b0, (im % 4096) != 0};
            3'd5: return {1'b0, (s < -1048576) || (s > 1048575) || (s % 2 != 0)};
            default: return 2'b10;
        endcase
    endfunction

    task automatic check_word(input item_t it, input logic [31:0] w,
                              input logic [1:0] e);
        logic [1:0]  ee;
        logic [31:0] gf, ef, gi;
        bit          has_imm;
        ee = exp_err(it.fmt, it.imm);
        chk("err", 32'(e), 32'(ee));
        if (it.has) chk("word", w, it.word);
        if (ee != 2'b00) begin
            chk("nop", w, NOP_WORD);
        end else begin
            chk("opcode", 32'(w[6:0]), 32'(it.op));
            has_imm = 1'b1;
            gi = '0;
            case (it.fmt)
                3'd0: begin
                    gf = {5'b0, w[31:25], w[24:20], w[19:15], w[14:12], w[11:7]};
                    ef = {5'b0, it.f7, it.rs2, it.rs1, it.f3, it.rd};
                    has_imm = 1'b0;
                end
                3'd1: begin
                    gf = {19'b0, w[19:15], w[14:12], w[11:7]};
                    ef = {19'b0, it.rs1, it.f3, it.rd};
                    gi = {{20{w[31]}}, w[31:20]};
                end
                3'd2, 3'd3: begin
                    gf = {19'b0, w[24:20], w[19:15], w[14:12]};
                    ef = {19'b0, it.rs2, it.rs1, it.f3};
                    if (it.fmt == 3'd2) gi = {{20{w[31]}}, w[31:25], w[11:7]};
                    else gi = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
                end
                default: begin
                    gf = {27'b0, w[11:7]};
                    ef = {27'b0, it.rd};
                    if (it.fmt == 3'd4) gi = {w[31:12], 12'b0};
                    else gi = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
                end
            endcase
            chk("fields", gf, ef);
            if (has_imm) chk("imm", gi, it.imm);
        end
    endtask

    // Called at a falling edge with inputs set; ends at the next falling edge.
    task automatic step();
        bit hs;
        #1;
        accepted = in_valid && in_ready;
        if (accepted) sb.push_back(cur);
        chk("lockstep", 32'(out_valid4), 32'(out_valid));
        chk("sticky", 32'(err_sticky), 32'(m_sticky));
        if (stalled && out_valid) begin
            chk("hold_instr", instr, p_instr);
            chk("hold_addr", addr, p_addr);
        end
        hs = out_valid && out_ready;
        if (hs) begin
            if (sb.size() == 0) begin
                chk("extra_word", 32'd1, 32'd0);
            end else begin
                check_word(sb.pop_front(), instr, out_err);
            end
            chk("addr", addr, m_addr);
            chk("addr4", 32'(addr4), 32'(m_addr[3:0]));
        end
        m_sticky = addr_clr ? 1'b0 : (m_sticky || (hs && (out_err != 2'b00)));
        m_addr   = addr_clr ? 32'd0 : (hs ? m_addr + 32'd4 : m_addr);
        stalled  = out_valid && !out_ready && !addr_clr;
        p_instr  = instr;
        p_addr   = addr;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input item_t it);
        int n;
        cur = it;
        in_valid = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!accepted && n < 50);
        if (!accepted) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 50) begin
            step();
            n++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic model_reset();
        sb.delete();
        m_addr = 32'd0;
        m_sticky = 1'b0;
        stalled = 1'b0;
    endtask

    initial begin
        item_t bp[4];
        int    idx;
        rst_n = 1'b0; in_valid = 1'b0; addr_clr = 1'b0; out_ready = 1'b1;
        cur = mk(0, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_addr", addr, 32'd0);
        chk("rst_err", 32'(out_err), 32'd0);
        chk("rst_sticky", 32'(err_sticky), 32'd0);
        rst_n = 1'b1;
        #1 chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        send(mk(1, 'h13, 1, 0, 0, 0, 0, 32'd5, 32'h0050_0093));
        in_valid = 1'b0;
        chk("lat_s1", 32'(out_valid), 32'd0);
        step();
        chk("lat_s2", 32'(out_valid), 32'd1);
        chk("lat_addr", addr, 32'd0);
        step();

        send(mk(0, 'h33, 3, 0, 1, 2, 0, 32'd0, 32'h0020_81B3));
        send(mk(2, 'h23, 0, 2, 1, 2, 0, 32'd8, 32'h0020_A423));
        send(mk(3, 'h63, 0, 0, 0, 0, 0, -32'sd4, 32'hFE00_0EE3));
        send(mk(4, 'h37, 5, 0, 0, 0, 0, 32'h1234_5000, 32'h1234_52B7));
        send(mk(5, 'h6F, 1, 0, 0, 0, 0, 32'd2048, 32'h0010_00EF));
        drain();
        chk("clean_sticky", 32'(err_sticky), 32'd0);

        send(mk(1, 'h13, 1, 0, 0, 0, 0, 32'd2048, NOP_WORD));
        send(mk(3, 'h63, 0, 0, 0, 0, 0, 32'd3, NOP_WORD));
        send(mk(6, 'h13, 0, 0, 0, 0, 0, 32'd0, NOP_WORD));
        drain();
        chk("err_sticky", 32'(err_sticky), 32'd1);
        addr_clr = 1'b1;
        step();
        addr_clr = 1'b0;
        chk("clr_addr", addr, 32'd0);
        chk("clr_sticky", 32'(err_sticky), 32'd0);

        for (int i = 0; i < 4; i++) begin
            bp[i] = rnd_item();
            bp[i].fmt = 3'd0;
        end
        idx = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cur = bp[idx];
            in_valid = 1'b1;
            step();
            if (accepted) idx++;
        end
        chk("bp_accepts", 32'(idx), 32'd2);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        for (int n = 0; n < 20 && idx < 4; n++) begin
            cur = bp[idx];
            step();
            if (accepted) idx++;
        end
        chk("bp_all_in", 32'(idx), 32'd4);
        drain();

        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cur = rnd_item();
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        chk("full_before_rst", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_addr", addr, 32'd0);
        chk("arst_addr4", 32'(addr4), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) send(rnd_item());
        drain();
        chk("wrap_addr4", 32'(addr4), 32'd4);

        for (int i = 0; i < 600; i++) begin
            cur = rnd_item();
            in_valid  = ($urandom_range(0, 9) < 8);
            out_ready = ($urandom_range(0, 3) != 0);
            addr_clr  = ($urandom_range(0, 39) == 0);
            step();
        end
        addr_clr = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
